// File: rtl/krnl_vadd_rtl_control_s_axi_if.sv
// AXI4-Lite control bus bundle (32-bit data) between host-side master and the vadd control slave.
interface krnl_vadd_rtl_control_s_axi_if #(
    parameter int ADDR_W = 6
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/krnl_vadd_rtl_control_s_axi.sv
// AXI4-Lite control/status slave for the vadd kernel: AP_CTRL handshake plus argument registers.
// Optional GIE/IER/ISR interrupt logic is built only when CTRL_INTERRUPT_EN is defined.
module krnl_vadd_rtl_control_s_axi #(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_ADDER_BIT_WIDTH  = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    krnl_vadd_rtl_control_s_axi_if.slave  s_axi,
    output logic                          ap_start,
    input  logic                          ap_done,
    output logic                          interrupt,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
    output logic [C_ADDER_BIT_WIDTH-1:0]  ctrl_constant
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    localparam logic [AW-1:0] ADDR_AP_CTRL = AW'(8'h00);
    localparam logic [AW-1:0] ADDR_GIE     = AW'(8'h04);
    localparam logic [AW-1:0] ADDR_IER     = AW'(8'h08);
    localparam logic [AW-1:0] ADDR_ISR     = AW'(8'h0C);
    localparam logic [AW-1:0] ADDR_CONST   = AW'(8'h10);
    localparam logic [AW-1:0] ADDR_ADDR_LO = AW'(8'h18);
    localparam logic [AW-1:0] ADDR_ADDR_HI = AW'(8'h1C);
    localparam logic [AW-1:0] ADDR_XFER    = AW'(8'h20);

    typedef enum logic [1:0] {
        WRIDLE = 2'd0,
        WRDATA = 2'd1,
        WRRESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        RDIDLE = 1'b0,
        RDDATA = 1'b1
    } rd_state_t;

    wr_state_t       r_wstate;
    wr_state_t       w_wstate_next;
    rd_state_t       r_rstate;
    rd_state_t       w_rstate_next;
    logic            r_rst_done;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_rdata;
    logic [DW-1:0]   w_rdata_next;

    logic            w_awready;
    logic            w_arready;
    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_ar_hs;
    logic            w_wr_ctrl;
    logic            w_start_req;

    logic            r_busy;
    logic            r_done;
    logic            r_auto_restart;
    logic            r_ap_start;
    logic [31:0]     r_constant;
    logic [31:0]     r_addr_lo;
    logic [31:0]     r_addr_hi;
    logic [31:0]     r_xfer;
    logic [63:0]     w_addr_full;

    logic            w_gie;
    logic            w_ier;
    logic            w_isr;
    logic            w_irq;

    function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Handshakes stay blocked until the first clock edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_rst_done <= 1'b0;
        else          r_rst_done <= 1'b1;
    end

    assign w_awready = r_rst_done && (r_wstate == WRIDLE);
    assign w_arready = r_rst_done && (r_rstate == RDIDLE);
    assign w_aw_hs   = s_axi.awvalid && w_awready;
    assign w_w_hs    = s_axi.wvalid && (r_wstate == WRDATA);
    assign w_ar_hs   = s_axi.arvalid && w_arready;

    assign s_axi.awready = w_awready;
    assign s_axi.wready  = (r_wstate == WRDATA);
    assign s_axi.bvalid  = (r_wstate == WRRESP);
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = w_arready;
    assign s_axi.rvalid  = (r_rstate == RDDATA);
    assign s_axi.rdata   = r_rdata[31:0];
    assign s_axi.rresp   = 2'b00;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_wstate <= WRIDLE;
        else          r_wstate <= w_wstate_next;
    end

    always_comb begin
        w_wstate_next = r_wstate;
        unique case (r_wstate)
            WRIDLE:  if (w_aw_hs)      w_wstate_next = WRDATA;
            WRDATA:  if (w_w_hs)       w_wstate_next = WRRESP;
            WRRESP:  if (s_axi.bready) w_wstate_next = WRIDLE;
            default:                   w_wstate_next = WRIDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)     r_waddr <= '0;
        else if (w_aw_hs) r_waddr <= s_axi.awaddr;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_rstate <= RDIDLE;
        else          r_rstate <= w_rstate_next;
    end

    always_comb begin
        w_rstate_next = r_rstate;
        unique case (r_rstate)
            RDIDLE:  if (w_ar_hs)      w_rstate_next = RDDATA;
            RDDATA:  if (s_axi.rready) w_rstate_next = RDIDLE;
            default:                   w_rstate_next = RDIDLE;
        endcase
    end

    // Read data is sampled once at the AR handshake and held until rready.
    always_comb begin
        w_rdata_next = '0;
        case (s_axi.araddr)
            ADDR_AP_CTRL: w_rdata_next[7:0]  = {r_auto_restart, 3'b000, ap_done, ~r_busy, r_done, r_busy};
            ADDR_GIE:     w_rdata_next[0]    = w_gie;
            ADDR_IER:     w_rdata_next[0]    = w_ier;
            ADDR_ISR:     w_rdata_next[0]    = w_isr;
            ADDR_CONST:   w_rdata_next[31:0] = r_constant;
            ADDR_ADDR_LO: w_rdata_next[31:0] = r_addr_lo;
            ADDR_ADDR_HI: w_rdata_next[31:0] = r_addr_hi;
            ADDR_XFER:    w_rdata_next[31:0] = r_xfer;
            default:      ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)     r_rdata <= '0;
        else if (w_ar_hs) r_rdata <= w_rdata_next;
    end

    assign w_wr_ctrl   = w_w_hs && (r_waddr == ADDR_AP_CTRL) && s_axi.wstrb[0];
    assign w_start_req = w_wr_ctrl && s_axi.wdata[0] && !r_busy;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_busy         <= 1'b0;
            r_ap_start     <= 1'b0;
            r_auto_restart <= 1'b0;
        end else begin
            r_ap_start <= 1'b0;
            if (w_start_req) begin
                r_busy     <= 1'b1;
                r_ap_start <= 1'b1;
            end else if (ap_done) begin
                r_busy     <= r_auto_restart;
                r_ap_start <= r_auto_restart;
            end
            if (w_wr_ctrl) r_auto_restart <= s_axi.wdata[7];
        end
    end

    // A completion arriving with the clearing read wins, so it is never lost.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                                      r_done <= 1'b0;
        else if (ap_done)                                  r_done <= 1'b1;
        else if (w_ar_hs && (s_axi.araddr == ADDR_AP_CTRL)) r_done <= 1'b0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_constant <= '0;
            r_addr_lo  <= '0;
            r_addr_hi  <= '0;
            r_xfer     <= '0;
        end else if (w_w_hs && !r_busy) begin
            case (r_waddr)
                ADDR_CONST:   r_constant <= wstrb_merge(r_constant, s_axi.wdata, s_axi.wstrb);
                ADDR_ADDR_LO: r_addr_lo  <= wstrb_merge(r_addr_lo,  s_axi.wdata, s_axi.wstrb);
                ADDR_ADDR_HI: r_addr_hi  <= wstrb_merge(r_addr_hi,  s_axi.wdata, s_axi.wstrb);
                ADDR_XFER:    r_xfer     <= wstrb_merge(r_xfer,     s_axi.wdata, s_axi.wstrb);
                default:      ;
            endcase
        end
    end

`ifdef CTRL_INTERRUPT_EN
    logic r_gie;
    logic r_ier;
    logic r_isr;
    logic r_irq;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_gie <= 1'b0;
            r_ier <= 1'b0;
            r_isr <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_w_hs && (r_waddr == ADDR_GIE) && s_axi.wstrb[0]) r_gie <= s_axi.wdata[0];
            if (w_w_hs && (r_waddr == ADDR_IER) && s_axi.wstrb[0]) r_ier <= s_axi.wdata[0];
            if (r_ier && ap_done)
                r_isr <= 1'b1;
            else if (w_w_hs && (r_waddr == ADDR_ISR) && s_axi.wstrb[0] && s_axi.wdata[0])
                r_isr <= ~r_isr;
            r_irq <= r_gie && r_isr;
        end
    end

    assign w_gie = r_gie;
    assign w_ier = r_ier;
    assign w_isr = r_isr;
    assign w_irq = r_irq;
`else
    assign w_gie = 1'b0;
    assign w_ier = 1'b0;
    assign w_isr = 1'b0;
    assign w_irq = 1'b0;
`endif

    assign w_addr_full             = {r_addr_hi, r_addr_lo};
    assign ap_start                = r_ap_start;
    assign interrupt               = w_irq;
    assign ctrl_addr_offset        = w_addr_full[C_M_AXI_ADDR_WIDTH-1:0];
    assign ctrl_xfer_size_in_bytes = r_xfer[C_XFER_SIZE_WIDTH-1:0];
    assign ctrl_constant           = r_constant[C_ADDER_BIT_WIDTH-1:0];

endmodule

// File: tb/tb_krnl_vadd_rtl_control_s_axi.sv
// Directed + randomized bench for krnl_vadd_rtl_control_s_axi against a register-map reference model.
module tb_krnl_vadd_rtl_control_s_axi;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        ap_start;
    logic        ap_done;
    logic        interrupt;
    logic [63:0] ctrl_addr_offset;
    logic [31:0] ctrl_xfer_size_in_bytes;
    logic [31:0] ctrl_constant;

    int errors = 0;
    int checks = 0;

    krnl_vadd_rtl_control_s_axi_if #(.ADDR_W(6)) s_axi ();

    krnl_vadd_rtl_control_s_axi dut (
        .aclk                    (aclk),
        .aresetn                 (aresetn),
        .s_axi                   (s_axi),
        .ap_start                (ap_start),
        .ap_done                 (ap_done),
        .interrupt               (interrupt),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ctrl_constant           (ctrl_constant)
    );

    always #5 aclk = ~aclk;

    // Reference model state
    logic [31:0] m_const;
    logic [63:0] m_addr;
    logic [31:0] m_xfer;
    bit          m_busy, m_done, m_auto, m_gie, m_ier, m_isr;

    logic [7:0] addrs [8] = '{8'h10, 8'h18, 8'h1C, 8'h20, 8'h14, 8'h24, 8'h2C, 8'h38};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_const = '0; m_addr = '0; m_xfer = '0;
        m_busy = 0; m_done = 0; m_auto = 0; m_gie = 0; m_ier = 0; m_isr = 0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic bit model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        bit st;
        st = 0;
        case (a)
            8'h00: if (s[0]) begin
                if (d[0] && !m_busy) begin m_busy = 1; st = 1; end
                m_auto = d[7];
            end
`ifdef CTRL_INTERRUPT_EN
            8'h04: if (s[0]) m_gie = d[0];
            8'h08: if (s[0]) m_ier = d[0];
            8'h0C: if (s[0] && d[0]) m_isr = !m_isr;
`endif
            8'h10: if (!m_busy) m_const = merge(m_const, d, s);
            8'h18: if (!m_busy) m_addr[31:0] = merge(m_addr[31:0], d, s);
            8'h1C: if (!m_busy) m_addr[63:32] = merge(m_addr[63:32], d, s);
            8'h20: if (!m_busy) m_xfer = merge(m_xfer, d, s);
            default: ;
        endcase
        return st;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a, input bit done_now);
        logic [31:0] v;
        v = '0;
        case (a)
            8'h00: begin
                v = {24'h0, m_auto, 3'b000, done_now, !m_busy, m_done, m_busy};
                m_done = 0;
            end
            8'h04: v = {31'h0, m_gie};
            8'h08: v = {31'h0, m_ier};
            8'h0C: v = {31'h0, m_isr};
            8'h10: v = m_const;
            8'h18: v = m_addr[31:0];
            8'h1C: v = m_addr[63:32];
            8'h20: v = m_xfer;
            default: ;
        endcase
        return v;
    endfunction

    function automatic bit model_done();
        m_done = 1;
        if (m_ier) m_isr = 1;
        m_busy = m_auto;
        return m_auto;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic st_first, output logic st_second);
        int n;
        n = 0;
        s_axi.awvalid = 1'b1;
        s_axi.awaddr  = a[5:0];
        while (s_axi.awready !== 1'b1 && n < 16) begin tick(); n++; end
        check("aw_wait", (n < 16), 1);
        tick();
        s_axi.awvalid = 1'b0;
        check("wready_after_aw", s_axi.wready, 1);
        check("bvalid_before_w", s_axi.bvalid, 0);
        s_axi.wvalid = 1'b1;
        s_axi.wdata  = d;
        s_axi.wstrb  = s;
        tick();
        s_axi.wvalid = 1'b0;
        st_first = ap_start;
        check("bvalid_1cyc", s_axi.bvalid, 1);
        check("bresp", s_axi.bresp, 0);
        s_axi.bready = 1'b1;
        tick();
        s_axi.bready = 1'b0;
        st_second = ap_start;
        check("bvalid_drop", s_axi.bvalid, 0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input string tag);
        logic f, sec;
        bit   exp_st;
        exp_st = model_write(a, d, s);
        axi_write(a, d, s, f, sec);
        check({tag, "_start"}, f, exp_st);
        check({tag, "_start_end"}, sec, 0);
    endtask

    task automatic axi_read(input logic [7:0] a, input bit done_now, input int hold,
                            input logic [31:0] exp, input string tag);
        int n;
        n = 0;
        s_axi.arvalid = 1'b1;
        s_axi.araddr  = a[5:0];
        while (s_axi.arready !== 1'b1 && n < 16) begin tick(); n++; end
        check("ar_wait", (n < 16), 1);
        if (done_now) ap_done = 1'b1;
        tick();
        s_axi.arvalid = 1'b0;
        ap_done       = 1'b0;
        check("rvalid_1cyc", s_axi.rvalid, 1);
        check("rresp", s_axi.rresp, 0);
        check(tag, s_axi.rdata, exp);
        for (int k = 0; k < hold; k++) begin
            tick();
            check("rvalid_hold", s_axi.rvalid, 1);
            check({tag, "_hold"}, s_axi.rdata, exp);
        end
        s_axi.rready = 1'b1;
        tick();
        s_axi.rready = 1'b0;
        check("rvalid_drop", s_axi.rvalid, 0);
    endtask

    task automatic read_model(input logic [7:0] a, input string tag);
        logic [31:0] e;
        e = model_read(a, 0);
        axi_read(a, 0, int'($urandom_range(0, 2)), e, tag);
    endtask

    task automatic pulse_done(input string tag);
        bit exp_st;
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        exp_st = model_done();
        check({tag, "_start"}, ap_start, exp_st);
        tick();
        check({tag, "_start_end"}, ap_start, 0);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_constant"}, ctrl_constant, m_const);
        check({tag, "_addr"}, ctrl_addr_offset, m_addr);
        check({tag, "_xfer"}, ctrl_xfer_size_in_bytes, m_xfer);
        check({tag, "_irq"}, interrupt, (m_gie && m_isr));
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d, e;
        logic [3:0]  s;
        int          n;

        s_axi.awvalid = 0; s_axi.awaddr = '0; s_axi.wvalid = 0; s_axi.wdata = '0;
        s_axi.wstrb = '0; s_axi.bready = 0; s_axi.arvalid = 0; s_axi.araddr = '0;
        s_axi.rready = 0; ap_done = 0; aresetn = 0;
        model_reset();

        #12;
        check("rst_awready", s_axi.awready, 0);
        check("rst_wready", s_axi.wready, 0);
        check("rst_arready", s_axi.arready, 0);
        check("rst_bvalid", s_axi.bvalid, 0);
        check("rst_rvalid", s_axi.rvalid, 0);
        check("rst_ap_start", ap_start, 0);
        check_outputs("rst");
        aresetn = 1;
        tick();
        check("post_rst_awready", s_axi.awready, 1);
        check("post_rst_arready", s_axi.arready, 1);
        read_model(8'h00, "rst_ap_ctrl");

        // Byte-lane write on the constant register
        do_write(8'h10, 32'hDEADBEEF, 4'hF, "const_full");
        do_write(8'h10, 32'h00000011, 4'h1, "const_lane0");
        check("const_lane_value", ctrl_constant, 32'hDEADBE11);
        axi_read(8'h10, 0, 2, model_read(8'h10, 0), "const_read");

        for (int i = 0; i < 12; i++) begin
            a = addrs[$urandom_range(0, 7)];
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, d, s, "rand_wr");
            check_outputs("rand");
        end
        for (int i = 0; i < 8; i++) read_model(addrs[i], "rand_rd");

        // Start handshake
        do_write(8'h00, 32'h1, 4'h1, "start1");
        read_model(8'h00, "busy_read");
        do_write(8'h00, 32'h1, 4'h1, "start_busy");
        do_write(8'h18, $urandom, 4'hF, "addr_busy");
        check_outputs("busy");
        pulse_done("done1");
        read_model(8'h00, "done_read");
        read_model(8'h00, "done_cleared");

        // ap_done coincident with AR handshake on AP_CTRL
        do_write(8'h00, 32'h1, 4'h1, "start2");
        e = model_read(8'h00, 1);
        void'(model_done());
        axi_read(8'h00, 1, 0, e, "coinc_read");
        read_model(8'h00, "coinc_after");
        read_model(8'h00, "coinc_cleared");

        // Auto-restart
        do_write(8'h00, 32'h81, 4'h1, "auto_start");
        read_model(8'h00, "auto_busy");
        pulse_done("auto_done");
        read_model(8'h00, "auto_after_done");
        read_model(8'h00, "auto_cleared");
        do_write(8'h1C, $urandom, 4'hF, "addr_hi_busy");
        do_write(8'h20, $urandom, 4'hF, "xfer_busy");
        check_outputs("auto");
        do_write(8'h00, 32'h0, 4'h1, "auto_off");
        pulse_done("final_done");
        read_model(8'h00, "final_read");

        // Interrupt path
        do_write(8'h04, 32'h1, 4'h1, "gie");
        do_write(8'h08, 32'h1, 4'h1, "ier");
        do_write(8'h00, 32'h1, 4'h1, "irq_start");
        pulse_done("irq_done");
        check_outputs("irq_set");
        read_model(8'h0C, "isr_read");
        read_model(8'h04, "gie_read");
        read_model(8'h08, "ier_read");
        do_write(8'h0C, 32'h1, 4'h1, "isr_toggle");
        check_outputs("irq_clr");
        read_model(8'h0C, "isr_read2");

        // Reset between AW and W handshakes
        s_axi.awaddr  = 6'h20;
        s_axi.awvalid = 1'b1;
        n = 0;
        while (s_axi.awready !== 1'b1 && n < 16) begin tick(); n++; end
        check("mid_aw_wait", (n < 16), 1);
        tick();
        s_axi.awvalid = 1'b0;
        check("mid_wready", s_axi.wready, 1);
        #2 aresetn = 0;
        #1;
        model_reset();
        check("mid_rst_wready", s_axi.wready, 0);
        check("mid_rst_awready", s_axi.awready, 0);
        check("mid_rst_arready", s_axi.arready, 0);
        check("mid_rst_bvalid", s_axi.bvalid, 0);
        check("mid_rst_ap_start", ap_start, 0);
        check_outputs("mid_rst");
        s_axi.wvalid = 1'b1;
        s_axi.wdata  = 32'hCAFEF00D;
        s_axi.wstrb  = 4'hF;
        tick();
        s_axi.wvalid = 1'b0;
        check("mid_rst_no_bvalid", s_axi.bvalid, 0);
        aresetn = 1;
        tick();
        check("rel_awready", s_axi.awready, 1);
        check("rel_arready", s_axi.arready, 1);
        check("rel_bvalid", s_axi.bvalid, 0);
        check_outputs("rel");
        do_write(8'h20, $urandom, 4'hF, "post_rst_wr");
        check_outputs("post_rst");
        read_model(8'h20, "post_rst_rd");
        read_model(8'h00, "post_rst_ctrl");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
